histo_cdf_engine: RTL and testbench



---
 rtl/histo_cdf_engine.sv | 267 ++++++++++++++++++++++++++
 tb/tb_histo_cdf_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/histo_cdf_engine.sv
// Streaming greyscale histogram and cumulative histogram engine.
// Ping-pong banks: one bank is displayed while the other accumulates the next frame.
module histo_cdf_engine #(
  parameter int unsigned PIX_BITS = 12,
  parameter int unsigned BIN_BITS = 8,
  parameter int unsigned CNT_BITS = 20
) (
  input  logic                iPclk,
  input  logic                iRST,
  input  logic [PIX_BITS-1:0] iGrey,
  input  logic                iDval,
  input  logic                iFval,
  input  logic [BIN_BITS-1:0] iRd_Bin,
  output logic [CNT_BITS-1:0] oHist,
  output logic [CNT_BITS-1:0] oCum,
  output logic                oFrame_Done,
  output logic                oDrop,
  output logic                oSat,
  output logic                oBusy
);

  localparam int unsigned         NBINS    = 1 << BIN_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [BIN_BITS-1:0] BIN_LAST = {BIN_BITS{1'b1}};

  typedef enum logic [1:0] {S_CLEAR, S_WAIT, S_ACCUM, S_CUMSUM} state_t;

  logic [CNT_BITS-1:0] hist_mem [2][NBINS];
  logic [CNT_BITS-1:0] cum_mem  [2][NBINS];

  state_t              state_q, state_d;
  logic [BIN_BITS-1:0] clr_addr_q, clr_addr_d;
  logic                clr_both_q, clr_both_d;
  logic                bank_q, bank_d;
  logic                fval_q, fval_d;
  logic                drain_q, drain_d;
  logic                s1_vld_q, s1_vld_d;
  logic [BIN_BITS-1:0] s1_bin_q, s1_bin_d;
  logic                s2_vld_q, s2_vld_d;
  logic [BIN_BITS-1:0] s2_bin_q, s2_bin_d;
  logic [CNT_BITS-1:0] s2_val_q, s2_val_d;
  logic                s3_vld_q, s3_vld_d;
  logic [BIN_BITS-1:0] s3_bin_q, s3_bin_d;
  logic [CNT_BITS-1:0] s3_val_q, s3_val_d;
  logic [CNT_BITS-1:0] rd_q, rd_d;
  logic [BIN_BITS-1:0] cs_rd_addr_q, cs_rd_addr_d;
  logic                cs_run_q, cs_run_d;
  logic                cs_wr_vld_q, cs_wr_vld_d;
  logic [BIN_BITS-1:0] cs_wr_bin_q, cs_wr_bin_d;
  logic [CNT_BITS-1:0] sum_q, sum_d;
  logic                sat_q, sat_d;
  logic [CNT_BITS-1:0] hist_q, hist_d;
  logic [CNT_BITS-1:0] cum_q, cum_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                osat_q, osat_d;
  logic                busy_q, busy_d;

  logic [BIN_BITS-1:0] pix_bin;
  logic [BIN_BITS-1:0] acc_raddr;
  logic [1:0]          acc_mask;
  logic                rise, fall;
  logic [CNT_BITS-1:0] base_val, inc_val;
  logic                inc_sat;
  logic [CNT_BITS:0]   cum_total;
  logic [CNT_BITS-1:0] cum_val;
  logic                cum_ovf;
  logic [1:0]          hist_we, cum_we;
  logic [BIN_BITS-1:0] hist_wa, cum_wa;
  logic [CNT_BITS-1:0] hist_wd, cum_wd;
  logic                unused_grey_lsbs;

  assign pix_bin          = iGrey[PIX_BITS-1 -: BIN_BITS];
  assign unused_grey_lsbs = ^iGrey[PIX_BITS-BIN_BITS-1:0];
  assign rise             = iFval & ~fval_q;
  assign fall             = ~iFval & fval_q;
  assign acc_mask         = bank_q ? 2'b01 : 2'b10;
  assign acc_raddr        = (state_q == S_CUMSUM) ? cs_rd_addr_q : pix_bin;

  // Increment stage: newest in-flight value wins over the stale RAM read.
  always_comb begin
    base_val = rd_q;
    if (s2_vld_q && (s2_bin_q == s1_bin_q)) begin
      base_val = s2_val_q;
    end else if (s3_vld_q && (s3_bin_q == s1_bin_q)) begin
      base_val = s3_val_q;
    end
    inc_sat   = (base_val == CNT_MAX);
    inc_val   = inc_sat ? CNT_MAX : base_val + CNT_BITS'(1);
    cum_total = {1'b0, sum_q} + {1'b0, rd_q};
    cum_ovf   = cum_total[CNT_BITS];
    cum_val   = cum_ovf ? CNT_MAX : cum_total[CNT_BITS-1:0];
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_both_d   = clr_both_q;
    bank_d       = bank_q;
    fval_d       = iFval;
    drain_d      = drain_q;
    s1_vld_d     = 1'b0;
    s1_bin_d     = pix_bin;
    s2_vld_d     = s1_vld_q;
    s2_bin_d     = s1_bin_q;
    s2_val_d     = inc_val;
    s3_vld_d     = s2_vld_q;
    s3_bin_d     = s2_bin_q;
    s3_val_d     = s2_val_q;
    rd_d         = hist_mem[~bank_q][acc_raddr];
    cs_rd_addr_d = cs_rd_addr_q;
    cs_run_d     = cs_run_q;
    cs_wr_vld_d  = 1'b0;
    cs_wr_bin_d  = cs_rd_addr_q;
    sum_d        = sum_q;
    sat_d        = sat_q;
    hist_d       = hist_mem[bank_q][iRd_Bin];
    cum_d        = cum_mem[bank_q][iRd_Bin];
    done_d       = 1'b0;
    drop_d       = 1'b0;
    osat_d       = osat_q;
    hist_we      = 2'b00;
    hist_wa      = s2_bin_q;
    hist_wd      = s2_val_q;
    cum_we       = 2'b00;
    cum_wa       = cs_wr_bin_q;
    cum_wd       = cum_val;

    if (s2_vld_q) hist_we = acc_mask;
    if (s1_vld_q && inc_sat) sat_d = 1'b1;

    case (state_q)
      S_CLEAR: begin
        hist_we    = clr_both_q ? 2'b11 : acc_mask;
        cum_we     = clr_both_q ? 2'b11 : acc_mask;
        hist_wa    = clr_addr_q;
        cum_wa     = clr_addr_q;
        hist_wd    = '0;
        cum_wd     = '0;
        clr_addr_d = clr_addr_q + BIN_BITS'(1);
        drop_d     = rise;
        if (clr_addr_q == BIN_LAST) begin
          state_d    = S_WAIT;
          clr_both_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (rise) begin
          state_d = S_ACCUM;
          drain_d = 1'b0;
        end
      end
      S_ACCUM: begin
        s1_vld_d = iDval & ~drain_q;
        if (!drain_q && fall) drain_d = 1'b1;
        // Leave only once the last write has landed in the RAM.
        if (drain_q && !s1_vld_q && !s2_vld_q) begin
          state_d      = S_CUMSUM;
          drain_d      = 1'b0;
          cs_rd_addr_d = '0;
          cs_run_d     = 1'b1;
          sum_d        = '0;
        end
      end
      S_CUMSUM: begin
        drop_d = rise;
        if (cs_run_q) begin
          cs_wr_vld_d  = 1'b1;
          cs_rd_addr_d = cs_rd_addr_q + BIN_BITS'(1);
          if (cs_rd_addr_q == BIN_LAST) cs_run_d = 1'b0;
        end
        if (cs_wr_vld_q) begin
          cum_we = acc_mask;
          sum_d  = cum_val;
          if (cum_ovf) sat_d = 1'b1;
          if (cs_wr_bin_q == BIN_LAST) begin
            bank_d     = ~bank_q;
            done_d     = 1'b1;
            osat_d     = sat_q | cum_ovf;
            sat_d      = 1'b0;
            state_d    = S_CLEAR;
            clr_addr_d = '0;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase

    busy_d = (state_d == S_CLEAR) || (state_d == S_CUMSUM);
  end

  always_ff @(posedge iPclk or posedge iRST) begin
    if (iRST) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      clr_both_q   <= 1'b1;
      bank_q       <= 1'b0;
      fval_q       <= 1'b0;
      drain_q      <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_bin_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_bin_q     <= '0;
      s2_val_q     <= '0;
      s3_vld_q     <= 1'b0;
      s3_bin_q     <= '0;
      s3_val_q     <= '0;
      rd_q         <= '0;
      cs_rd_addr_q <= '0;
      cs_run_q     <= 1'b0;
      cs_wr_vld_q  <= 1'b0;
      cs_wr_bin_q  <= '0;
      sum_q        <= '0;
      sat_q        <= 1'b0;
      hist_q       <= '0;
      cum_q        <= '0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
      osat_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_both_q   <= clr_both_d;
      bank_q       <= bank_d;
      fval_q       <= fval_d;
      drain_q      <= drain_d;
      s1_vld_q     <= s1_vld_d;
      s1_bin_q     <= s1_bin_d;
      s2_vld_q     <= s2_vld_d;
      s2_bin_q     <= s2_bin_d;
      s2_val_q     <= s2_val_d;
      s3_vld_q     <= s3_vld_d;
      s3_bin_q     <= s3_bin_d;
      s3_val_q     <= s3_val_d;
      rd_q         <= rd_d;
      cs_rd_addr_q <= cs_rd_addr_d;
      cs_run_q     <= cs_run_d;
      cs_wr_vld_q  <= cs_wr_vld_d;
      cs_wr_bin_q  <= cs_wr_bin_d;
      sum_q        <= sum_d;
      sat_q        <= sat_d;
      hist_q       <= hist_d;
      cum_q        <= cum_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
      osat_q       <= osat_d;
      busy_q       <= busy_d;
    end
  end

  // One write port per memory; contents are initialised by the CLEAR walk.
  always_ff @(posedge iPclk) begin
    for (int b = 0; b < 2; b++) begin
      if (hist_we[b]) hist_mem[b][hist_wa] <= hist_wd;
      if (cum_we[b])  cum_mem[b][cum_wa]   <= cum_wd;
    end
  end

  assign oHist       = hist_q;
  assign oCum        = cum_q;
  assign oFrame_Done = done_q;
  assign oDrop       = drop_q;
  assign oSat        = osat_q;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_histo_cdf_engine.sv
// Directed bench for histo_cdf_engine: full-bank sweeps against hand-built histograms,
// plus saturation (narrow-counter instance), frame drop and mid-frame reset sequences.
module tb_histo_cdf_engine;

  localparam int unsigned NB = 256;

  typedef struct {
    logic [7:0]  bin;
    logic [19:0] hist;
    logic [19:0] cum;
  } vec_t;

  logic        iPclk = 1'b0;
  logic        iRST;
  logic [11:0] iGrey;
  logic        iDval;
  logic        iFval;
  logic [7:0]  iRd_Bin;
  logic [19:0] oHist, oCum;
  logic        oFrame_Done, oDrop, oSat, oBusy;
  logic [3:0]  d4_hist, d4_cum;
  logic        d4_sat, d4_busy, unused_d4_done, unused_d4_drop;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned done_cnt = 0;
  int unsigned drop_cnt = 0;
  int unsigned exp_h [NB];
  vec_t        tbl [NB];
  logic [11:0] pixq [$];

  histo_cdf_engine dut (
    .iPclk(iPclk), .iRST(iRST), .iGrey(iGrey), .iDval(iDval), .iFval(iFval),
    .iRd_Bin(iRd_Bin), .oHist(oHist), .oCum(oCum), .oFrame_Done(oFrame_Done),
    .oDrop(oDrop), .oSat(oSat), .oBusy(oBusy)
  );

  histo_cdf_engine #(.CNT_BITS(4)) dut4 (
    .iPclk(iPclk), .iRST(iRST), .iGrey(iGrey), .iDval(iDval), .iFval(iFval),
    .iRd_Bin(iRd_Bin), .oHist(d4_hist), .oCum(d4_cum), .oFrame_Done(unused_d4_done),
    .oDrop(unused_d4_drop), .oSat(d4_sat), .oBusy(d4_busy)
  );

  always #5 iPclk = ~iPclk;

  always @(negedge iPclk) begin
    if (oFrame_Done) done_cnt <= done_cnt + 1;
    if (oDrop) drop_cnt <= drop_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iPclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < NB; k++) exp_h[k] = 0;
  endtask

  // Expected cumulative values are the running sum of the hand-set bin counts.
  task automatic sweep(input string tag);
    int unsigned run;
    run = 0;
    for (int k = 0; k < NB; k++) begin
      run += exp_h[k];
      tbl[k].bin  = 8'(k);
      tbl[k].hist = 20'(exp_h[k]);
      tbl[k].cum  = 20'(run);
    end
    for (int k = 0; k < NB; k++) begin
      iRd_Bin = tbl[k].bin;
      tick();
      check($sformatf("%s hist[%0d]", tag, k), 32'(oHist), 32'(tbl[k].hist));
      check($sformatf("%s cum[%0d]", tag, k), 32'(oCum), 32'(tbl[k].cum));
    end
  endtask

  task automatic run_frame();
    iFval = 1'b1;
    repeat (3) tick();
    foreach (pixq[i]) begin
      iGrey = pixq[i];
      iDval = 1'b1;
      tick();
    end
    iDval = 1'b0;
    tick();
    iFval = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string tag);
    int unsigned start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 3000) begin
      tick();
      n++;
    end
    n = 0;
    while (oBusy && n < 1000) begin
      tick();
      n++;
    end
    check({tag, " idle"}, 32'(oBusy), 32'd0);
    check({tag, " done pulses"}, done_cnt - start, 32'd1);
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (oBusy && n < 1000);
    check({tag, " clear cycles"}, 32'(n), 32'd256);
  endtask

  initial begin
    iRST = 1'b1; iGrey = '0; iDval = 1'b0; iFval = 1'b0; iRd_Bin = '0;
    repeat (3) tick();
    check("rst busy", 32'(oBusy), 32'd1);
    check("rst busy4", 32'(d4_busy), 32'd1);
    check("rst hist", 32'(oHist), 32'd0);
    check("rst cum", 32'(oCum), 32'd0);
    check("rst done", 32'(oFrame_Done), 32'd0);
    check("rst drop", 32'(oDrop), 32'd0);
    check("rst sat", 32'(oSat), 32'd0);
    iRST = 1'b0;
    count_clear("reset");
    clear_exp();
    sweep("empty");

    // Single-bin flat frame
    pixq.delete();
    for (int i = 0; i < 1024; i++) pixq.push_back(12'h7F0);
    run_frame();
    wait_done("flat");
    clear_exp();
    exp_h[127] = 1024;
    sweep("flat");
    check("flat sat", 32'(oSat), 32'd0);
    check("flat drops", drop_cnt, 32'd0);

    // Ramp: each bin hit four times
    pixq.delete();
    for (int i = 0; i < 1024; i++) pixq.push_back(12'(i * 16));
    run_frame();
    wait_done("ramp");
    for (int k = 0; k < NB; k++) exp_h[k] = 4;
    sweep("ramp");

    // Back-to-back and two-apart hits on the same bin
    pixq.delete();
    begin
      logic [7:0] hz [11];
      hz = '{8'd3, 8'd3, 8'd3, 8'd5, 8'd3, 8'd5, 8'd7, 8'd8, 8'd7, 8'd9, 8'd7};
      foreach (hz[i]) pixq.push_back({hz[i], 4'(i)});
    end
    run_frame();
    wait_done("hazard");
    clear_exp();
    exp_h[3] = 4; exp_h[5] = 2; exp_h[7] = 3; exp_h[8] = 1; exp_h[9] = 1;
    sweep("hazard");

    // Saturation on the 4-bit counter instance, then a clean frame
    pixq.delete();
    for (int i = 0; i < 20; i++) pixq.push_back(12'h00C);
    run_frame();
    wait_done("sat");
    clear_exp();
    exp_h[0] = 20;
    sweep("sat");
    check("sat main flag", 32'(oSat), 32'd0);
    iRd_Bin = 8'd0;
    tick();
    check("sat4 hist[0]", 32'(d4_hist), 32'd15);
    iRd_Bin = 8'd255;
    tick();
    check("sat4 cum[255]", 32'(d4_cum), 32'd15);
    check("sat4 flag", 32'(d4_sat), 32'd1);

    pixq.delete();
    pixq.push_back(12'h010);
    pixq.push_back(12'h01F);
    run_frame();
    wait_done("clean");
    iRd_Bin = 8'd1;
    tick();
    check("clean4 hist[1]", 32'(d4_hist), 32'd2);
    iRd_Bin = 8'd0;
    tick();
    check("clean4 hist[0]", 32'(d4_hist), 32'd0);
    check("clean4 flag", 32'(d4_sat), 32'd0);

    // Frame start during CUMSUM is dropped; following frame is captured
    pixq.delete();
    for (int i = 0; i < 5; i++) pixq.push_back(12'h0A0);
    run_frame();
    repeat (8) tick();
    iFval = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      iGrey = 12'h140;
      iDval = 1'b1;
      tick();
    end
    iDval = 1'b0;
    iFval = 1'b0;
    tick();
    wait_done("drop");
    check("drop pulses", drop_cnt, 32'd1);
    clear_exp();
    exp_h[10] = 5;
    sweep("drop");
    pixq.delete();
    for (int i = 0; i < 3; i++) pixq.push_back(12'h1E0);
    run_frame();
    wait_done("after drop");
    clear_exp();
    exp_h[30] = 3;
    sweep("after drop");
    check("after drop pulses", drop_cnt, 32'd1);

    // Reset in the middle of accumulation discards everything
    iFval = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      iGrey = 12'h280;
      iDval = 1'b1;
      tick();
    end
    iDval = 1'b0;
    iFval = 1'b0;
    iRST = 1'b1;
    tick();
    check("midrst busy", 32'(oBusy), 32'd1);
    check("midrst sat", 32'(oSat), 32'd0);
    tick();
    iRST = 1'b0;
    count_clear("midrst");
    clear_exp();
    sweep("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
